// File: rtl/lvds_training_aligner_if.sv
// -----------------------------------------------------------------------------
// lvds_training_aligner_if
// Bundles the signals between the sensor controller / deserializer bank and the
// training aligner.
//   master : controller + deserializer side (drives command, pattern, rx words)
//   slave  : aligner side (drives bitslip pulses and training status)
// Signals:
//   cmd_start_training  level request, rising edge starts a training run
//   training_pattern    expected training word
//   rx_data             deserialized words, lane k at [k*DATA_W +: DATA_W]
//   bitslip             one-cycle bitslip pulse per lane
//   training_done       training finished (pass or fail)
//   training_error      some lane failed to align
//   lane_locked         per-lane alignment achieved
//   fail_lane           index of the failing lane (valid with training_error)
// -----------------------------------------------------------------------------
interface lvds_training_aligner_if #(
   parameter int DATA_W = 10,
   parameter int N_CH   = 4,
   parameter int LANE_W = 2
);
   logic                     cmd_start_training;
   logic [DATA_W-1:0]        training_pattern;
   logic [N_CH*DATA_W-1:0]   rx_data;
   logic [N_CH-1:0]          bitslip;
   logic                     training_done;
   logic                     training_error;
   logic [N_CH-1:0]          lane_locked;
   logic [LANE_W-1:0]        fail_lane;

   modport master (
      output cmd_start_training, training_pattern, rx_data,
      input  bitslip, training_done, training_error, lane_locked, fail_lane
   );

   modport slave (
      input  cmd_start_training, training_pattern, rx_data,
      output bitslip, training_done, training_error, lane_locked, fail_lane
   );
endinterface

// File: rtl/lvds_training_aligner.sv
// -----------------------------------------------------------------------------
// lvds_training_aligner
// Responder side of the sensor training handshake. On a rising edge of
// cmd_start_training each LVDS lane is word-aligned in turn by comparing its
// deserialized word against the latched training pattern and issuing bitslip
// pulses until MATCH_CNT consecutive words match. A lane that still mismatches
// after all DATA_W bit positions were tried ends the run with training_error.
// Ports:
//   clk_rxg   receive word clock
//   rst_rx_n  asynchronous active-low reset
//   bus       lvds_training_aligner_if.slave (command, pattern, rx words in;
//             bitslip, done, error, lane_locked, fail_lane out; all registered)
// -----------------------------------------------------------------------------
module lvds_training_aligner #(
   parameter int DATA_W     = 10,
   parameter int N_CH       = 4,
   parameter int LANE_W     = 2,
   parameter int SETTLE_CYC = 8,
   parameter int MATCH_CNT  = 16
) (
   input  logic                     clk_rxg,
   input  logic                     rst_rx_n,
   lvds_training_aligner_if.slave   bus
);
   localparam int SLIP_W   = $clog2(DATA_W) + 1;
   localparam int MATCH_W  = $clog2(MATCH_CNT + 1);
   localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);

   typedef enum logic [6:0] {
      ST_IDLE   = 7'b0000001,
      ST_SETTLE = 7'b0000010,
      ST_CHECK  = 7'b0000100,
      ST_SLIP   = 7'b0001000,
      ST_NEXT   = 7'b0010000,
      ST_DONE   = 7'b0100000,
      ST_FAIL   = 7'b1000000
   } state_t;

   state_t              state_q, state_d;
   logic                cmd_q, cmd_d;
   logic [DATA_W-1:0]   pat_q, pat_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [SLIP_W-1:0]   slip_q, slip_d;
   logic [MATCH_W-1:0]  match_q, match_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [N_CH-1:0]     bitslip_q, bitslip_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [N_CH-1:0]     locked_q, locked_d;
   logic [LANE_W-1:0]   fail_q, fail_d;

   logic                start_s;
   logic                cmd_s;
   logic [DATA_W-1:0]   word_s;
   logic [N_CH-1:0]     lane_bit_s;

   assign cmd_s      = bus.cmd_start_training;
   assign start_s    = cmd_s & ~cmd_q;
   assign word_s     = bus.rx_data[32'(lane_q) * DATA_W +: DATA_W];
   assign lane_bit_s = N_CH'(1) << lane_q;

   // Next-state and next-output logic; dropping the command aborts any busy state.
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_s;
      pat_d     = pat_q;
      lane_d    = lane_q;
      slip_d    = slip_q;
      match_d   = match_q;
      settle_d  = settle_q;
      bitslip_d = '0;
      done_d    = done_q;
      err_d     = err_q;
      locked_d  = locked_q;
      fail_d    = fail_q;
      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               pat_d    = bus.training_pattern;
               lane_d   = '0;
               slip_d   = '0;
               match_d  = '0;
               locked_d = '0;
               err_d    = 1'b0;
               fail_d   = '0;
               done_d   = 1'b0;
               settle_d = SETTLE_W'(SETTLE_CYC - 1);
               state_d  = ST_SETTLE;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (!cmd_s) begin
               state_d = ST_IDLE;
            end else if (settle_q == '0) begin
               state_d = ST_CHECK;
            end else begin
               settle_d = settle_q - SETTLE_W'(1);
            end
         end
         ST_CHECK: begin
            if (!cmd_s) begin
               state_d = ST_IDLE;
            end else if (word_s == pat_q) begin
               if (match_q == MATCH_W'(MATCH_CNT - 1)) begin
                  locked_d = locked_q | lane_bit_s;
                  state_d  = ST_NEXT;
               end else begin
                  match_d  = match_q + MATCH_W'(1);
               end
            end else if (slip_q == SLIP_W'(DATA_W - 1)) begin
               // every bit position has been tried on this lane
               fail_d  = lane_q;
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = ST_FAIL;
            end else begin
               // pulse is registered, so it is visible during the SLIP cycle
               bitslip_d = lane_bit_s;
               state_d   = ST_SLIP;
            end
         end
         ST_SLIP: begin
            if (!cmd_s) begin
               state_d = ST_IDLE;
            end else begin
               slip_d   = slip_q + SLIP_W'(1);
               match_d  = '0;
               settle_d = SETTLE_W'(SETTLE_CYC - 1);
               state_d  = ST_SETTLE;
            end
         end
         ST_NEXT: begin
            if (!cmd_s) begin
               state_d = ST_IDLE;
            end else if (lane_q == LANE_W'(N_CH - 1)) begin
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               lane_d   = lane_q + LANE_W'(1);
               slip_d   = '0;
               match_d  = '0;
               settle_d = SETTLE_W'(SETTLE_CYC - 1);
               state_d  = ST_SETTLE;
            end
         end
         ST_DONE, ST_FAIL: begin
            if (!cmd_s) begin
               done_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               done_d  = 1'b1;
            end
         end
         default: begin
            done_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counter and output registers.
   always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
      if (!rst_rx_n) begin
         state_q   <= ST_IDLE;
         cmd_q     <= 1'b0;
         pat_q     <= '0;
         lane_q    <= '0;
         slip_q    <= '0;
         match_q   <= '0;
         settle_q  <= '0;
         bitslip_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         locked_q  <= '0;
         fail_q    <= '0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         pat_q     <= pat_d;
         lane_q    <= lane_d;
         slip_q    <= slip_d;
         match_q   <= match_d;
         settle_q  <= settle_d;
         bitslip_q <= bitslip_d;
         done_q    <= done_d;
         err_q     <= err_d;
         locked_q  <= locked_d;
         fail_q    <= fail_d;
      end
   end

   assign bus.bitslip        = bitslip_q;
   assign bus.training_done  = done_q;
   assign bus.training_error = err_q;
   assign bus.lane_locked    = locked_q;
   assign bus.fail_lane      = fail_q;
endmodule

// File: tb/tb_lvds_training_aligner.sv
// -----------------------------------------------------------------------------
// tb_lvds_training_aligner
// Emulates the deserializer bank (each lane presents the training word rotated
// by a per-lane amount; every bitslip undoes one bit of rotation) and predicts
// the aligner outputs from a timeline model: lane start times, bitslip pulse
// times, lock times and done/fail times derived arithmetically per lane.
// -----------------------------------------------------------------------------
module tb_lvds_training_aligner;
   localparam int DATA_W     = 10;
   localparam int N_CH       = 4;
   localparam int LANE_W     = 2;
   localparam int SETTLE_CYC = 8;
   localparam int MATCH_CNT  = 16;
   // timeline constants: first compare edge after a lane starts, cost of one slip,
   // and the length of a lane that needs no slip
   localparam int FIRST_CHK  = SETTLE_CYC + 1;
   localparam int SLIP_COST  = SETTLE_CYC + 2;
   localparam int LANE_BASE  = SETTLE_CYC + MATCH_CNT + 1;

   logic clk_rxg  = 1'b0;
   logic rst_rx_n = 1'b0;
   always #5 clk_rxg = ~clk_rxg;

   lvds_training_aligner_if #(.DATA_W(DATA_W), .N_CH(N_CH), .LANE_W(LANE_W)) bus ();

   lvds_training_aligner #(
      .DATA_W(DATA_W), .N_CH(N_CH), .LANE_W(LANE_W),
      .SETTLE_CYC(SETTLE_CYC), .MATCH_CNT(MATCH_CNT)
   ) dut (
      .clk_rxg (clk_rxg),
      .rst_rx_n(rst_rx_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   logic [N_CH-1:0]   exp_bs, exp_locked;
   logic              exp_done, exp_err;
   logic [LANE_W-1:0] exp_fail;

   int          rot [N_CH];
   bit          dead[N_CH];
   logic [9:0]  dead_word;
   logic [9:0]  run_pat;

   int t_lane[N_CH];
   int r_lane[N_CH];
   int fail_k, fin_t, n_lanes;

   int slip_seen[N_CH];
   int last_slip[N_CH];
   int min_gap, first_done;
   logic [N_CH-1:0] lock0;

   function automatic logic [9:0] rotl(input logic [9:0] w, input int r);
      logic [19:0] t;
      t = {w, w} << r;
      return t[19:10];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // lane timeline from the per-lane rotation / dead configuration
   task automatic plan();
      int t;
      int found;
      t = 0; fail_k = -1; n_lanes = N_CH; fin_t = 0;
      for (int k = 0; k < N_CH; k++) begin
         if (fail_k < 0) begin
            t_lane[k] = t;
            if (dead[k]) begin
               fail_k  = k;
               n_lanes = k + 1;
               fin_t   = t + FIRST_CHK + SLIP_COST * (DATA_W - 1);
            end else begin
               found = -1;
               for (int j = 0; j < DATA_W; j++)
                  if (found < 0 && rotl(run_pat, (rot[k] - j + DATA_W) % DATA_W) == run_pat)
                     found = j;
               r_lane[k] = found;
               t = t + LANE_BASE + SLIP_COST * found;
            end
         end
      end
      if (fail_k < 0) fin_t = t;
   endtask

   task automatic model_at(input int n, output logic [N_CH-1:0] bs, output logic [N_CH-1:0] lk,
                           output logic dn, output logic er, output logic [LANE_W-1:0] fl);
      bs = '0; lk = '0; dn = 1'b0; er = 1'b0; fl = '0;
      for (int k = 0; k < n_lanes; k++) begin
         if (dead[k]) begin
            for (int j = 0; j < DATA_W - 1; j++)
               if (n == t_lane[k] + FIRST_CHK + SLIP_COST * j) bs[k] = 1'b1;
            if (n >= fin_t) begin er = 1'b1; dn = 1'b1; fl = LANE_W'(k); end
         end else begin
            for (int j = 0; j < r_lane[k]; j++)
               if (n == t_lane[k] + FIRST_CHK + SLIP_COST * j) bs[k] = 1'b1;
            if (n >= t_lane[k] + FIRST_CHK + SLIP_COST * r_lane[k] + MATCH_CNT - 1) lk[k] = 1'b1;
         end
      end
      if (fail_k < 0 && n >= fin_t) dn = 1'b1;
   endtask

   task automatic drive_rx();
      for (int k = 0; k < N_CH; k++)
         bus.rx_data[k*DATA_W +: DATA_W] = dead[k] ? dead_word : rotl(run_pat, rot[k]);
   endtask

   // one clock: a bitslip seen at the edge removes one bit of rotation
   task automatic tick();
      logic [N_CH-1:0] bs;
      bs = bus.bitslip;
      @(posedge clk_rxg);
      #1;
      for (int k = 0; k < N_CH; k++)
         if (bs[k]) rot[k] = (rot[k] + DATA_W - 1) % DATA_W;
      drive_rx();
   endtask

   task automatic idle(input int c);
      repeat (c) tick();
   endtask

   task automatic run(input logic [9:0] pat, input int abort_at, input int pat_change_at,
                      input int reset_at, input int hold);
      int m;
      m = -1;
      run_pat = pat;
      bus.training_pattern = pat;
      drive_rx();
      plan();
      for (int k = 0; k < N_CH; k++) begin slip_seen[k] = 0; last_slip[k] = -1000; end
      min_gap = 100000; first_done = -1;
      bus.cmd_start_training = 1'b1;
      for (int n = 0; n < 20000; n++) begin
         tick();
         if (reset_at >= 0 && n >= reset_at) begin
            exp_bs = '0; exp_locked = '0; exp_done = 1'b0; exp_err = 1'b0; exp_fail = '0;
         end else if (m >= 0 && n >= m) begin
            model_at(m - 1, exp_bs, exp_locked, exp_done, exp_err, exp_fail);
            exp_bs = '0; exp_done = 1'b0;
         end else begin
            model_at(n, exp_bs, exp_locked, exp_done, exp_err, exp_fail);
         end
         if (n == 0) lock0 = bus.lane_locked;
         for (int k = 0; k < N_CH; k++)
            if (bus.bitslip[k]) begin
               slip_seen[k]++;
               if (n - last_slip[k] < min_gap) min_gap = n - last_slip[k];
               last_slip[k] = n;
            end
         if (bus.training_done && first_done < 0) first_done = n;
         if (n == pat_change_at) bus.training_pattern = pat ^ 10'h2D5;
         if (reset_at >= 0) begin
            if (n == reset_at) begin
               #2 rst_rx_n = 1'b0;
               #1;
               chk("rst_async_bitslip", 32'(bus.bitslip), 32'(0));
               chk("rst_async_done", 32'(bus.training_done), 32'(0));
               chk("rst_async_error", 32'(bus.training_error), 32'(0));
               chk("rst_async_locked", 32'(bus.lane_locked), 32'(0));
               chk("rst_async_fail_lane", 32'(bus.fail_lane), 32'(0));
               bus.cmd_start_training = 1'b0;
            end
            if (n == reset_at + 3) rst_rx_n = 1'b1;
            if (n == reset_at + 6) break;
         end else begin
            if (m < 0 && ((abort_at >= 0 && n == abort_at) || (abort_at < 0 && n == fin_t + hold))) begin
               bus.cmd_start_training = 1'b0;
               m = n + 1;
            end
            if (m >= 0 && n == m + 2) break;
         end
      end
   endtask

   task automatic set_lanes(input int r0, input int r1, input int r2, input int r3);
      rot[0] = r0; rot[1] = r1; rot[2] = r2; rot[3] = r3;
      for (int k = 0; k < N_CH; k++) dead[k] = 1'b0;
   endtask

   // per-cycle comparison of every DUT output against the model
   always @(negedge clk_rxg) begin
      if (chk_en) begin
         chk("bitslip", 32'(bus.bitslip), 32'(exp_bs));
         chk("training_done", 32'(bus.training_done), 32'(exp_done));
         chk("training_error", 32'(bus.training_error), 32'(exp_err));
         chk("lane_locked", 32'(bus.lane_locked), 32'(exp_locked));
         chk("fail_lane", 32'(bus.fail_lane), 32'(exp_fail));
      end
   end

   initial begin
      int ab, hold, pc;
      logic [9:0] p;
      bus.cmd_start_training = 1'b0;
      bus.training_pattern   = '0;
      bus.rx_data            = '0;
      exp_bs = '0; exp_locked = '0; exp_done = 1'b0; exp_err = 1'b0; exp_fail = '0;
      set_lanes(0, 0, 0, 0);
      dead_word = '0; run_pat = '0;
      chk_en = 1'b1;
      repeat (3) @(posedge clk_rxg);
      #1;
      chk("reset_done", 32'(bus.training_done), 32'(0));
      chk("reset_bitslip", 32'(bus.bitslip), 32'(0));
      rst_rx_n = 1'b1;
      idle(2);

      // all lanes aligned
      set_lanes(0, 0, 0, 0);
      run(10'h2AA, -1, -1, -1, 3);
      chk("t1_model_done_time", 32'(fin_t), 32'(100));
      chk("t1_first_done", 32'(first_done), 32'(100));
      chk("t1_locked", 32'(bus.lane_locked), 32'(4'hF));
      chk("t1_slips", 32'(slip_seen[0] + slip_seen[1] + slip_seen[2] + slip_seen[3]), 32'(0));
      chk("t1_error", 32'(bus.training_error), 32'(0));

      // restart with a new pattern: locks cleared at start
      run(10'h3F0, -1, -1, -1, 1);
      chk("t4_locked_cleared", 32'(lock0), 32'(0));
      chk("t4_first_done", 32'(first_done), 32'(100));
      chk("t4_locked", 32'(bus.lane_locked), 32'(4'hF));

      // lane 2 rotated by 3
      set_lanes(0, 0, 3, 0);
      run(10'h3F0, -1, -1, -1, 2);
      chk("t2_model_slips", 32'(r_lane[2]), 32'(3));
      chk("t2_slips_lane2", 32'(slip_seen[2]), 32'(3));
      chk("t2_slips_other", 32'(slip_seen[0] + slip_seen[1] + slip_seen[3]), 32'(0));
      chk("t2_gap_ok", 32'(min_gap >= SETTLE_CYC + 2), 32'(1));
      chk("t2_first_done", 32'(first_done), 32'(130));
      chk("t2_locked", 32'(bus.lane_locked), 32'(4'hF));

      // lane 1 never matches
      set_lanes(0, 0, 0, 0);
      dead[1] = 1'b1; dead_word = 10'h000;
      run(10'h2AA, -1, -1, -1, 2);
      chk("t3_slips_lane1", 32'(slip_seen[1]), 32'(9));
      chk("t3_slips_lane23", 32'(slip_seen[2] + slip_seen[3]), 32'(0));
      chk("t3_first_done", 32'(first_done), 32'(124));
      chk("t3_error", 32'(bus.training_error), 32'(1));
      chk("t3_fail_lane", 32'(bus.fail_lane), 32'(1));
      chk("t3_locked", 32'(bus.lane_locked), 32'(4'b0001));

      // abort in lane 1 CHECK
      set_lanes(0, 0, 0, 0);
      run(10'h2AA, 40, -1, -1, 0);
      idle(20);
      chk("t5_no_done", 32'(first_done), 32'(-1));
      chk("t5_locked_partial", 32'(bus.lane_locked), 32'(4'b0001));

      // reset mid-SETTLE
      run(10'h2AA, -1, -1, 3, 0);
      idle(2);

      // pattern port changes during training
      set_lanes(1, 0, 2, 0);
      run(10'h3F0, -1, 5, -1, 1);
      chk("t6_locked", 32'(bus.lane_locked), 32'(4'hF));
      chk("t6_error", 32'(bus.training_error), 32'(0));

      // randomized runs
      for (int it = 0; it < 14; it++) begin
         p = 10'($urandom_range(0, 1023));
         set_lanes($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
         dead_word = ~p;
         if ($urandom_range(0, 2) == 0) dead[$urandom_range(0, N_CH - 1)] = 1'b1;
         run_pat = p;
         plan();
         ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, fin_t - 1) : -1;
         pc   = ($urandom_range(0, 1) == 0) ? $urandom_range(1, fin_t) : -1;
         hold = $urandom_range(0, 4);
         run(p, ab, pc, -1, hold);
         idle($urandom_range(1, 4));
      end

      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
